// File: rtl/fe_pkg.sv
// Shared types for the field-multiplier arbiter: element width, element type and FSM states.
package fe_pkg;

  localparam int FE_W = 255;

  typedef logic [FE_W-1:0] fe_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP,
    GAP
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first asserted request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IW = $clog2(NREQ);

  always_comb begin
    idx_o = '0;
    // Scan from the farthest offset to the nearest so the index closest to ptr_i is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[IW'((int'(ptr_i) + k) % NREQ)]) idx_o = IW'((int'(ptr_i) + k) % NREQ);
    end
  end

  assign any_o = |req_i;

  always_comb begin
    gnt_o = '0;
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fe_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one mod-p field multiplier among NREQ requesters.
// Define FE_MUL_ARB_WDOG_EN to build the RUN-state watchdog (TIMEOUT cycles) that drives rsp_err.
module fe_mul_arbiter
  import fe_pkg::*;
#(
  parameter int N       = FE_W,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 8192
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*N-1:0]       req_x,
  input  logic [NREQ*N-1:0]       req_y,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [N-1:0]            rsp_prod,
  output logic                    rsp_err,
  output logic                    mul_go,
  output logic [N-1:0]            mul_x,
  output logic [N-1:0]            mul_y,
  input  logic [N-1:0]            mul_prod,
  input  logic                    mul_rdy
);

  localparam int IW = $clog2(NREQ);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] id_q;
  logic          first_q;
  logic [N-1:0]  mul_x_q, mul_y_q, rsp_prod_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            mul_done, wdog_hit;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req_i(req_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  // The multiplier's ready flag may still be high from the previous operation on the first RUN cycle.
  assign mul_done = (state_q == RUN) && !first_q && mul_rdy;

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_gnt;
          state_d   = RUN;
        end
      end
      RUN:     if (mul_done || wdog_hit) state_d = RESP;
      RESP:    state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      first_q    <= 1'b0;
      mul_x_q    <= '0;
      mul_y_q    <= '0;
      rsp_prod_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_any) begin
        mul_x_q <= req_x[int'(pick_idx)*N +: N];
        mul_y_q <= req_y[int'(pick_idx)*N +: N];
        id_q    <= pick_idx;
        first_q <= 1'b1;
      end
      if (state_q == RUN) first_q <= 1'b0;
      if (mul_done) rsp_prod_q <= mul_prod;
      else if (wdog_hit) rsp_prod_q <= '0;
      if (state_q == RESP) rr_ptr_q <= (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
    end
  end

`ifdef FE_MUL_ARB_WDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wdog_cnt_q;
  logic          err_q;

  // Fires on the TIMEOUT-th RUN cycle unless a genuine ready arrives on that same cycle.
  assign wdog_hit = (state_q == RUN) && !mul_done && (wdog_cnt_q == CW'(TIMEOUT - 1));
  assign rsp_err  = rsp_valid && err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == IDLE) wdog_cnt_q <= '0;
      else if (state_q == RUN) wdog_cnt_q <= wdog_cnt_q + CW'(1);
      if (state_q == IDLE) err_q <= 1'b0;
      else if (wdog_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign wdog_hit       = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  assign mul_go    = (state_q == RUN);
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_prod  = rsp_prod_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Randomised bench for fe_mul_arbiter with a stub multiplier and a cycle-level behavioural model.
module tb_fe_mul_arbiter;

  localparam int N    = 255;
  localparam int NREQ = 4;
`ifdef FE_MUL_ARB_WDOG_EN
  localparam int TO = 16;
`else
  localparam int TO = 8192;
`endif
  localparam logic [N-1:0] ALL1 = {N{1'b1}};
  localparam logic [N-1:0] P    = ALL1 - 255'd18;
  localparam logic [N-1:0] BIG  =
    255'h328f70e6_1c5b9a0d_44e2f7c1_9b3a6d08_5e7f1a2c_6d4b8e90_3f2a1c7d_9e8b2c18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [NREQ-1:0]         rv;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*N-1:0]       req_x, req_y;
  logic                    rsp_valid, rsp_err, mul_go;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic [N-1:0]            rsp_prod, mul_x, mul_y;
  logic [N-1:0]            mul_prod = '0;
  logic                    mul_rdy  = 1'b0;

  logic [N-1:0] rx[NREQ];
  logic [N-1:0] ry[NREQ];
  bit [NREQ-1:0] hold;
  bit stub_dead;

  int npass = 0, ntot = 0, nrsp = 0;
  int glog[$];
  logic [N-1:0] rsp_prods[$];
  int rsp_ids[$];
  bit rsp_errs[$];

  fe_mul_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_prod(rsp_prod), .rsp_err(rsp_err), .mul_go(mul_go), .mul_x(mul_x),
    .mul_y(mul_y), .mul_prod(mul_prod), .mul_rdy(mul_rdy)
  );

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*N +: N] = rx[i];
      req_y[i*N +: N] = ry[i];
    end
  end

  function automatic logic [N-1:0] modmul(logic [N-1:0] a, logic [N-1:0] b);
    logic [511:0] w;
    w = {257'b0, a} * {257'b0, b};
    w = w % {257'b0, P};
    return w[N-1:0];
  endfunction

  function automatic logic [N-1:0] rnd255();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return ALL1;
      default: return w[N-1:0];
    endcase
  endfunction

  task automatic chk(string name, logic [N-1:0] act, logic [N-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Stub multiplier: ready stays high (stale) until the next run clears it, then rises after 1..5 cycles.
  int scnt = 0, lat = 1;
  always @(posedge clk) begin
    if (!mul_go) scnt <= 0;
    else begin
      scnt <= scnt + 1;
      if (scnt == 0) begin
        mul_rdy <= 1'b0;
        lat     <= $urandom_range(1, 5);
      end else if (scnt == lat && !stub_dead) begin
        mul_rdy  <= 1'b1;
        mul_prod <= modmul(mul_x, mul_y);
      end
    end
  end

  // Behavioural model: an operation granted at cycle g runs from g+1 until the first cycle >= g+2
  // with mul_rdy (or the watchdog limit), responds one cycle later, and frees the arbiter two after that.
  int  cyc = 0, g_cyc = 0, d_cyc = -1, m_ptr = 0, p_id = 0;
  bit  m_busy = 0, m_err = 0, post_rst = 0, had_op = 0;
  int  low_run = 0, hi_run = 0, last_hi = 0;
  logic [N-1:0] p_x, p_y, p_prod;

  always @(negedge clk) begin
    int gi;
    logic [NREQ-1:0] er;
    bit eg, ersp;
    cyc++;
    if (rst) begin
      m_busy = 0; m_ptr = 0; post_rst = 1; had_op = 0; hi_run = 0; low_run = 0;
    end else begin
      if (post_rst) begin
        post_rst = 0;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_prod", rsp_prod, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_mul_go", mul_go, 0);
        chk("rst_mul_x", mul_x, 0);
        chk("rst_mul_y", mul_y, 0);
      end
      if (m_busy && d_cyc < 0 && cyc >= g_cyc + 2 && mul_rdy) begin
        d_cyc = cyc; m_err = 0; p_prod = modmul(p_x, p_y);
      end
`ifdef FE_MUL_ARB_WDOG_EN
      else if (m_busy && d_cyc < 0 && cyc == g_cyc + TO) begin
        d_cyc = cyc; m_err = 1; p_prod = '0;
      end
`endif
      eg   = m_busy && cyc > g_cyc && (d_cyc < 0 || cyc <= d_cyc);
      ersp = m_busy && d_cyc >= 0 && cyc == d_cyc + 1;
      if (m_busy && d_cyc >= 0 && cyc >= d_cyc + 3) m_busy = 0;
      gi = -1;
      if (!m_busy)
        for (int k = 0; k < NREQ; k++)
          if (gi < 0 && rv[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
      er = (gi >= 0) ? (NREQ'(1) << gi) : '0;
      chk("req_ready", req_ready, er);
      chk("mul_go", mul_go, eg);
      chk("rsp_valid", rsp_valid, ersp);
      chk("rsp_err", rsp_err, ersp && m_err);
      if (eg) begin
        chk("mul_x", mul_x, p_x);
        chk("mul_y", mul_y, p_y);
      end
      if (ersp) begin
        chk("rsp_id", rsp_id, p_id);
        chk("rsp_prod", rsp_prod, p_prod);
        rsp_ids.push_back(int'(rsp_id));
        rsp_prods.push_back(rsp_prod);
        rsp_errs.push_back(rsp_err);
        nrsp++;
        m_ptr = (p_id + 1) % NREQ;
      end
      if (gi >= 0) begin
        m_busy = 1; g_cyc = cyc; d_cyc = -1; p_id = gi; p_x = rx[gi]; p_y = ry[gi];
        glog.push_back(gi);
      end
      if (mul_go) begin
        if (hi_run == 0 && had_op) chk("go_low_gap", low_run >= 2, 1);
        hi_run++; low_run = 0; had_op = 1;
      end else begin
        if (hi_run > 0) last_hi = hi_run;
        hi_run = 0; low_run++;
      end
    end
  end

  task automatic step();
    logic [NREQ-1:0] r;
    @(negedge clk);
    r = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (r[i]) begin
        if (hold[i]) begin rx[i] = rnd255(); ry[i] = rnd255(); end
        else rv[i] = 1'b0;
      end
  endtask

  task automatic issue(int i, logic [N-1:0] x, logic [N-1:0] y);
    rx[i] = x; ry[i] = y; rv[i] = 1'b1;
  endtask

  task automatic wait_rsp(int target, int budget, string name);
    int b = 0;
    while (nrsp < target && b < budget) begin step(); b++; end
    if (nrsp < target) begin
      ntot++;
      $display("FAIL %s: timeout with %0d responses, required %0d", name, nrsp, target);
    end
  endtask

  task automatic drain(int budget);
    int b = 0;
    while ((m_busy || (|rv)) && b < budget) begin step(); b++; end
    if (m_busy || (|rv)) begin
      ntot++;
      $display("FAIL drain: busy=%0d valid=%0b required idle", m_busy, rv);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "stopped");
  end

  initial begin
    int gb, rb, b, g0, pos, n0;
    bit found;
    logic [N-1:0] ce[4];
    rst = 1'b1; rv = '0; hold = '0; stub_dead = 0;
    for (int i = 0; i < NREQ; i++) begin rx[i] = '0; ry[i] = '0; end

    chk("pin_5x12", modmul(255'd5, 255'd12), 255'd60);
    chk("pin_all1_sq", modmul(ALL1, ALL1), 255'd324);
    chk("pin_pm1_sq", modmul(P - 255'd1, P - 255'd1), 255'd1);
    chk("pin_big_all1", modmul(BIG, ALL1), modmul(BIG, 255'd18));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step();

    issue(0, 255'd5, 255'd12);
    wait_rsp(nrsp + 1, 60, "single");
    chk("single_id", rsp_ids[$], 0);
    chk("single_prod", rsp_prods[$], 255'd60);
    drain(20);

    issue(3, rnd255(), rnd255());
    wait_rsp(nrsp + 1, 60, "ptr_to_0");
    drain(20);
    gb = glog.size(); rb = rsp_prods.size();
    issue(0, ALL1, '0); issue(1, '0, ALL1); issue(2, 255'd2, 255'd3); issue(3, 255'd7, 255'd7);
    ce[0] = '0; ce[1] = '0; ce[2] = 255'd6; ce[3] = 255'd49;
    wait_rsp(nrsp + 4, 200, "concurrent");
    for (int k = 0; k < 4; k++) begin
      if (glog.size() > gb + k) chk($sformatf("conc_grant%0d", k), glog[gb + k], k);
      if (rsp_prods.size() > rb + k) begin
        chk($sformatf("conc_id%0d", k), rsp_ids[rb + k], k);
        chk($sformatf("conc_prod%0d", k), rsp_prods[rb + k], ce[k]);
      end
    end
    drain(20);

    hold[1] = 1; issue(1, rnd255(), rnd255());
    g0 = glog.size(); b = 0;
    while (glog.size() == g0 && b < 50) begin step(); b++; end
    issue(3, 255'd11, 255'd13);
    g0 = glog.size(); b = 0; found = 0; pos = 99;
    while (!found && b < 200) begin
      step(); b++;
      for (int j = g0; j < glog.size(); j++) if (!found && glog[j] == 3) begin found = 1; pos = j - g0; end
    end
    chk("fair_r3_within_2", found && pos <= 1, 1);
    hold[1] = 0; rv[1] = 1'b0;
    drain(100);

    issue(2, BIG, ALL1);
    wait_rsp(nrsp + 1, 60, "big");
    chk("big_prod", rsp_prods[$], modmul(BIG, 255'd18));
    drain(20);

    for (int c = 0; c < 500; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!rv[i]) begin
          if ($urandom_range(0, 5) == 0) issue(i, rnd255(), rnd255());
        end else if ($urandom_range(0, 19) == 0) rv[i] = 1'b0;
      end
    end
    drain(300);

    issue(2, rnd255(), rnd255());
    b = 0;
    while (!mul_go && b < 50) begin step(); b++; end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n0 = nrsp;
    repeat (10) step();
    chk("rst_no_rsp", nrsp, n0);
    issue(0, 255'd9, 255'd9);
    wait_rsp(nrsp + 1, 60, "after_rst");
    chk("after_rst_id", rsp_ids[$], 0);
    chk("after_rst_prod", rsp_prods[$], 255'd81);
    drain(20);

`ifdef FE_MUL_ARB_WDOG_EN
    stub_dead = 1;
    issue(1, 255'd3, 255'd4);
    wait_rsp(nrsp + 1, 100, "wdog");
    chk("wdog_err", rsp_errs[$], 1);
    chk("wdog_prod", rsp_prods[$], 0);
    chk("wdog_run_len", last_hi, TO);
    drain(20);
    stub_dead = 0;
    issue(0, 255'd4, 255'd5);
    wait_rsp(nrsp + 1, 60, "after_wdog");
    chk("after_wdog_err", rsp_errs[$], 0);
    chk("after_wdog_prod", rsp_prods[$], 255'd20);
    drain(20);
`endif

    repeat (5) step();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
